// File: rtl/btb_pkg.sv
// Shared types for the BTB update scheduler: update record, scheduler states, default widths.
// Optional in-place coalescing of buffered updates is enabled with BTB_COALESCE_EN.
package btb_pkg;

  localparam int BTB_ADDR_W   = 32;
  localparam int BTB_UPDATE_W = 2 * BTB_ADDR_W + 1;

  typedef struct packed {
    logic [BTB_ADDR_W-1:0] pc;
    logic [BTB_ADDR_W-1:0] target;
    logic                  outcome;
  } btb_update_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Dual-push / single-pop FIFO of BTB updates; push0 lands in the lower slot when both push.
// With BTB_COALESCE_EN a lookup/overwrite port can rewrite any buffered non-head entry in place.
module btb_update_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      flush,
  input  logic                      push0,
  input  logic [BTB_UPDATE_W-1:0]   data0,
  input  logic                      push1,
  input  logic [BTB_UPDATE_W-1:0]   data1,
  input  logic                      pop,
  output logic [BTB_UPDATE_W-1:0]   head,
  output logic [$clog2(DEPTH):0]    occupancy
`ifdef BTB_COALESCE_EN
  ,
  input  logic [BTB_ADDR_W-1:0]     lookup_pc0,
  input  logic [BTB_ADDR_W-1:0]     lookup_pc1,
  output logic                      hit0,
  output logic [$clog2(DEPTH)-1:0]  idx0,
  output logic                      hit1,
  output logic [$clog2(DEPTH)-1:0]  idx1,
  input  logic                      ovr0,
  input  logic [$clog2(DEPTH)-1:0]  ovr0_idx,
  input  logic [BTB_ADDR_W-1:0]     ovr0_target,
  input  logic                      ovr0_outcome,
  input  logic                      ovr1,
  input  logic [$clog2(DEPTH)-1:0]  ovr1_idx,
  input  logic [BTB_ADDR_W-1:0]     ovr1_target,
  input  logic                      ovr1_outcome
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  btb_update_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;
  logic [CW-1:0] count;

  assign wr_ptr1   = push0 ? wr_ptr + PW'(1) : wr_ptr;
  assign head      = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr1 + PW'(push1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Storage needs no reset: the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= data0;
    if (push1) mem[wr_ptr1] <= data1;
`ifdef BTB_COALESCE_EN
    if (ovr0) begin
      mem[ovr0_idx].target  <= ovr0_target;
      mem[ovr0_idx].outcome <= ovr0_outcome;
    end
    if (ovr1) begin
      mem[ovr1_idx].target  <= ovr1_target;
      mem[ovr1_idx].outcome <= ovr1_outcome;
    end
`endif
  end

`ifdef BTB_COALESCE_EN
  // Offset 0 is the head, which may already be on the BTB port, so the search starts at 1.
  always_comb begin
    hit0 = 1'b0;
    idx0 = '0;
    hit1 = 1'b0;
    idx1 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (!hit0 && mem[rd_ptr + PW'(i)].pc == lookup_pc0) begin
          hit0 = 1'b1;
          idx0 = rd_ptr + PW'(i);
        end
        if (!hit1 && mem[rd_ptr + PW'(i)].pc == lookup_pc1) begin
          hit1 = 1'b1;
          idx1 = rd_ptr + PW'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/btb_update_scheduler.sv
// Buffers resolved-branch updates from two requesters and drives the BTB's single update port.
// Owns the RUN/FLUSH/ACK clear sequence. BTB_COALESCE_EN merges same-PC updates in place.
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BTB_ADDR_W
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_pc,
  input  logic [ADDR_W-1:0]        req0_target,
  input  logic                     req0_outcome,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_pc,
  input  logic [ADDR_W-1:0]        req1_target,
  input  logic                     req1_outcome,
  output logic                     req1_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     btb_update_en,
  output logic [ADDR_W-1:0]        btb_update_pc,
  output logic [ADDR_W-1:0]        btb_update_target,
  output logic                     btb_update_outcome,
  output logic                     btb_clear,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: an update transfers on a rising edge where reqN_valid && reqN_ready;
  // ready may depend on valid in the same cycle and never on a pop in that cycle.
  sched_state_t            state;
  sched_state_t            state_next;
  logic                    run;
  logic                    rr;
  logic                    issue;
  logic                    sv0, sv1;
  logic                    slot_r0, slot_r1;
  logic                    push0, push1;
  logic                    ovr0, ovr1;
  logic                    contend;
  logic [CW-1:0]           occ;
  logic [CW-1:0]           free;
  logic [BTB_UPDATE_W-1:0] head_w;
  btb_update_t             head;
  btb_update_t             last;
`ifdef BTB_COALESCE_EN
  logic                    same;
  logic                    hit0, hit1;
  logic [$clog2(DEPTH)-1:0] idx0, idx1;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = FLUSH;
      FLUSH:   state_next = ACK;
      ACK:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run        = (state == RUN) && !clear;
    btb_clear  = (state == FLUSH);
    flush_done = (state == ACK);
    fsm_state  = state;
  end

  assign free = CW'(DEPTH) - occ;

  // sv0/sv1 mark requesters that need a fresh slot; coalescing requesters do not.
  always_comb begin
    sv0  = req0_valid;
    sv1  = req1_valid;
    ovr0 = 1'b0;
    ovr1 = 1'b0;
`ifdef BTB_COALESCE_EN
    same = req0_valid && req1_valid && (req0_pc == req1_pc);
    ovr1 = req1_valid && hit1;
    ovr0 = req0_valid && hit0 && !same;
    sv0  = req0_valid && !hit0 && !same;
    sv1  = req1_valid && !hit1;
`endif
    slot_r0 = 1'b0;
    slot_r1 = 1'b0;
    if (free >= CW'(2)) begin
      slot_r0 = 1'b1;
      slot_r1 = 1'b1;
    end else if (free == CW'(1)) begin
      slot_r0 = sv0 ? (!sv1 || !rr) : (!sv1 && !rr);
      slot_r1 = sv1 ? (!sv0 || rr)  : (!sv0 && rr);
    end
    push0      = run && sv0 && slot_r0;
    push1      = run && sv1 && slot_r1;
    contend    = run && sv0 && sv1 && (free == CW'(1));
    req0_ready = run && (slot_r0 || ovr0);
    req1_ready = run && (slot_r1 || ovr1);
`ifdef BTB_COALESCE_EN
    if (same) req0_ready = req1_ready;
`endif
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)        rr <= 1'b0;
    else if (contend) rr <= ~rr;
  end

  btb_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .clear        (clear),
    .flush        (state == FLUSH),
    .push0        (push0),
    .data0        ({req0_pc, req0_target, req0_outcome}),
    .push1        (push1),
    .data1        ({req1_pc, req1_target, req1_outcome}),
    .pop          (issue),
    .head         (head_w),
    .occupancy    (occ)
`ifdef BTB_COALESCE_EN
    ,
    .lookup_pc0   (req0_pc),
    .lookup_pc1   (req1_pc),
    .hit0         (hit0),
    .idx0         (idx0),
    .hit1         (hit1),
    .idx1         (idx1),
    .ovr0         (run && ovr0),
    .ovr0_idx     (idx0),
    .ovr0_target  (req0_target),
    .ovr0_outcome (req0_outcome),
    .ovr1         (run && ovr1),
    .ovr1_idx     (idx1),
    .ovr1_target  (req1_target),
    .ovr1_outcome (req1_outcome)
`endif
  );

  assign head  = head_w;
  assign issue = run && (occ != '0);

  // The head is presented while it is being popped; `last` keeps the fields stable otherwise.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)      last <= '0;
    else if (issue) last <= head;
  end

  assign btb_update_en      = issue;
  assign btb_update_pc      = issue ? head.pc      : last.pc;
  assign btb_update_target  = issue ? head.target  : last.target;
  assign btb_update_outcome = issue ? head.outcome : last.outcome;
  assign occupancy          = occ;

endmodule
